// File: rtl/tlb_refill_walker_if.sv
// Bundle of the miss-request, memory-read and TLB-write signals of the
// hardware TLB refill walker. The walker uses the master view and its
// environment (MMU, memory, testbench) uses the slave view.
interface tlb_refill_walker_if #(
  parameter int TLB_ENTRIES = 64
);
  localparam int IW = $clog2(TLB_ENTRIES);

  // Miss request side
  logic          missReq;
  logic [31:0]   missVAddr;
  logic [7:0]    asid;
  logic [31:0]   ptBase;
  logic [IW-1:0] wired;
  logic          busy;
  logic          done;
  logic          fault;

  // Memory read port
  logic          memReq;
  logic [31:0]   memAddr;
  logic          memAck;
  logic [31:0]   memData;

  // TLB write port
  logic          writeTlb;
  logic [IW-1:0] index;
  logic [31:0]   entryHi;
  logic [31:0]   entryLo0;
  logic [31:0]   entryLo1;
  logic [IW-1:0] random;

  modport master (
    input  missReq, missVAddr, asid, ptBase, wired, memAck, memData,
    output busy, done, fault, memReq, memAddr,
           writeTlb, index, entryHi, entryLo0, entryLo1, random
  );

  modport slave (
    output missReq, missVAddr, asid, ptBase, wired, memAck, memData,
    input  busy, done, fault, memReq, memAddr,
           writeTlb, index, entryHi, entryLo0, entryLo1, random
  );
endinterface

// File: rtl/tlb_refill_walker.sv
// Hardware TLB refill walker: on a miss it reads the EntryLo0/EntryLo1
// pair of the faulting VPN2 from the linear page table, then either writes
// the pair into the TLB entry selected by the Random counter or reports a
// page fault when the PTE of the faulting page is invalid. All outputs are
// registered; the write/done/fault decision is taken on the Lo1 ack edge so
// that it appears in the CHECK cycle.
module tlb_refill_walker #(
  parameter int TLB_ENTRIES = 64
) (
  input logic                 clk,
  input logic                 res,
  tlb_refill_walker_if.master bus
);
  localparam int IW = $clog2(TLB_ENTRIES);
  localparam logic [IW-1:0] RAND_TOP = IW'(TLB_ENTRIES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RD0   = 2'd1;
  localparam logic [1:0] S_RD1   = 2'd2;
  localparam logic [1:0] S_CHECK = 2'd3;

  // Walk state and latched request
  logic [1:0]    state_r;
  logic [1:0]    state_next_s;
  logic [31:0]   pte_addr_r;
  logic [18:0]   vpn2_r;
  logic          odd_r;
  logic [7:0]    asid_r;
  logic [31:0]   lo0_r;

  // Registered outputs
  logic          busy_r;
  logic          done_r;
  logic          fault_r;
  logic          mem_req_r;
  logic [31:0]   mem_addr_r;
  logic          write_tlb_r;
  logic [IW-1:0] index_r;
  logic [31:0]   entry_hi_r;
  logic [31:0]   entry_lo0_r;
  logic [31:0]   entry_lo1_r;
  logic [IW-1:0] random_r;

  // Combinational helpers
  logic [31:0]   pte_new_s;
  logic [31:0]   mem_addr_next_s;
  logic [31:0]   sel_pte_s;
  logic          pte_valid_s;
  logic          finish_s;
  logic [IW-1:0] rand_next_s;

  // Address bits below the page-table granularity never reach the walker
  logic          unused_s;
  assign unused_s = ^{bus.ptBase[22:0], bus.missVAddr[11:0]};

  assign pte_new_s   = {bus.ptBase[31:23], bus.missVAddr[31:13], 4'b0000};
  assign finish_s    = (state_r == S_RD1) && bus.memAck;
  // Lo1 is still on memData in the finishing cycle, Lo0 is already latched
  assign sel_pte_s   = odd_r ? bus.memData : lo0_r;
  assign pte_valid_s = sel_pte_s[1];

  // Next walk state
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.missReq) state_next_s = S_RD0;
        else             state_next_s = S_IDLE;
      end
      S_RD0: begin
        if (bus.memAck) state_next_s = S_RD1;
        else            state_next_s = S_RD0;
      end
      S_RD1: begin
        if (bus.memAck) state_next_s = S_CHECK;
        else            state_next_s = S_RD1;
      end
      S_CHECK: state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Read address for the coming cycle; on entry to RD0 the latch is not yet loaded
  always_comb begin
    mem_addr_next_s = 32'd0;
    case (state_next_s)
      S_RD0: begin
        if (state_r == S_IDLE) mem_addr_next_s = pte_new_s;
        else                   mem_addr_next_s = pte_addr_r;
      end
      S_RD1:   mem_addr_next_s = pte_addr_r + 32'd4;
      default: mem_addr_next_s = 32'd0;
    endcase
  end

  // Random replacement: count down, wrap to the top once at or below wired
  always_comb begin
    if (random_r <= bus.wired) rand_next_s = RAND_TOP;
    else                       rand_next_s = random_r - IW'(1);
  end

  // Random counter register, free-running regardless of walk state
  always_ff @(posedge clk) begin
    if (res) random_r <= RAND_TOP;
    else     random_r <= rand_next_s;
  end

  // Walk state, request latch and Lo0 capture
  always_ff @(posedge clk) begin
    if (res) begin
      state_r    <= S_IDLE;
      pte_addr_r <= 32'd0;
      vpn2_r     <= 19'd0;
      odd_r      <= 1'b0;
      asid_r     <= 8'd0;
      lo0_r      <= 32'd0;
    end else begin
      state_r <= state_next_s;
      if ((state_r == S_IDLE) && bus.missReq) begin
        pte_addr_r <= pte_new_s;
        vpn2_r     <= bus.missVAddr[31:13];
        odd_r      <= bus.missVAddr[12];
        asid_r     <= bus.asid;
      end
      if ((state_r == S_RD0) && bus.memAck) begin
        lo0_r <= bus.memData;
      end
    end
  end

  // Output registers; the TLB entry fields only change on a real write
  always_ff @(posedge clk) begin
    if (res) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      fault_r     <= 1'b0;
      mem_req_r   <= 1'b0;
      mem_addr_r  <= 32'd0;
      write_tlb_r <= 1'b0;
      index_r     <= '0;
      entry_hi_r  <= 32'd0;
      entry_lo0_r <= 32'd0;
      entry_lo1_r <= 32'd0;
    end else begin
      busy_r      <= (state_next_s != S_IDLE);
      mem_req_r   <= (state_next_s == S_RD0) || (state_next_s == S_RD1);
      mem_addr_r  <= mem_addr_next_s;
      write_tlb_r <= finish_s && pte_valid_s;
      done_r      <= finish_s && pte_valid_s;
      fault_r     <= finish_s && !pte_valid_s;
      if (finish_s && pte_valid_s) begin
        // rand_next_s is exactly what random shows during CHECK
        index_r     <= rand_next_s;
        entry_hi_r  <= {vpn2_r, 5'b00000, asid_r};
        entry_lo0_r <= lo0_r;
        entry_lo1_r <= bus.memData;
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.fault    = fault_r;
  assign bus.memReq   = mem_req_r;
  assign bus.memAddr  = mem_addr_r;
  assign bus.writeTlb = write_tlb_r;
  assign bus.index    = index_r;
  assign bus.entryHi  = entry_hi_r;
  assign bus.entryLo0 = entry_lo0_r;
  assign bus.entryLo1 = entry_lo1_r;
  assign bus.random   = random_r;
endmodule

// File: tb/tb_tlb_refill_walker.sv
// Directed bench for tlb_refill_walker: reset values, Random wrap, basic
// refill, odd-page fault, wait states, back-to-back walks, reset mid-walk.
module tb_tlb_refill_walker;
  logic clk;
  logic res;
  int   vectors;
  int   miscompares;
  logic [5:0] m_rand;
  logic [5:0] last_idx;

  tlb_refill_walker_if #(.TLB_ENTRIES(64)) bus ();

  tlb_refill_walker #(.TLB_ENTRIES(64)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, expected end before 200000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock edge; the Random reference follows reset and the wired boundary
  task automatic tick();
    @(posedge clk);
    if (res)                 m_rand = 6'd63;
    else if (m_rand <= bus.wired) m_rand = 6'd63;
    else                     m_rand = m_rand - 6'd1;
    #1;
  endtask

  task automatic start_walk(input logic [31:0] va, input logic [7:0] a, input bit hold);
    bus.missVAddr = va;
    bus.asid      = a;
    bus.missReq   = 1'b1;
    tick();
    if (!hold) bus.missReq = 1'b0;
  endtask

  // Serve one read: check request stability for waits+1 cycles, ack on the last
  task automatic serve(input string tag, input logic [31:0] addr, input logic [31:0] data, input int waits);
    for (int w = 0; w <= waits; w++) begin
      chk({tag, " memReq"}, 32'(bus.memReq), 32'd1);
      chk({tag, " memAddr"}, bus.memAddr, addr);
      chk({tag, " writeTlb idle"}, 32'(bus.writeTlb), 32'd0);
      if (w == waits) begin
        bus.memAck  = 1'b1;
        bus.memData = data;
      end
      tick();
      bus.memAck  = 1'b0;
      bus.memData = 32'hDEAD_BEEF;
    end
  endtask

  initial begin
    clk = 1'b0; res = 1'b1; vectors = 0; miscompares = 0;
    m_rand = 6'd63; last_idx = 6'd0;
    bus.missReq = 1'b0; bus.missVAddr = 32'd0; bus.asid = 8'd0;
    bus.ptBase = 32'h8000_0000; bus.wired = 6'd8;
    bus.memAck = 1'b0; bus.memData = 32'd0;

    // Reset values
    tick(); tick();
    chk("rst busy",     32'(bus.busy),     32'd0);
    chk("rst done",     32'(bus.done),     32'd0);
    chk("rst fault",    32'(bus.fault),    32'd0);
    chk("rst memReq",   32'(bus.memReq),   32'd0);
    chk("rst memAddr",  bus.memAddr,       32'd0);
    chk("rst writeTlb", 32'(bus.writeTlb), 32'd0);
    chk("rst index",    32'(bus.index),    32'd0);
    chk("rst entryHi",  bus.entryHi,       32'd0);
    chk("rst entryLo0", bus.entryLo0,      32'd0);
    chk("rst entryLo1", bus.entryLo1,      32'd0);
    chk("rst random",   32'(bus.random),   32'd63);
    res = 1'b0;

    // Random wrap with wired=8: 63 down to 8, then 63 again (period 56)
    for (int i = 0; i <= 56; i++) begin
      chk("wrap random", 32'(bus.random), (i < 56) ? 32'(63 - i) : 32'd63);
      tick();
    end

    // Basic refill, even page
    start_walk(32'h0040_2ABC, 8'h05, 1'b0);
    chk("basic busy c1", 32'(bus.busy), 32'd1);
    serve("basic rd0", 32'h8000_2010, 32'h0000_1007, 0);
    serve("basic rd1", 32'h8000_2014, 32'h0000_2007, 0);
    chk("basic writeTlb", 32'(bus.writeTlb), 32'd1);
    chk("basic done",     32'(bus.done),     32'd1);
    chk("basic fault",    32'(bus.fault),    32'd0);
    chk("basic busy c3",  32'(bus.busy),     32'd1);
    chk("basic entryHi",  bus.entryHi,       32'h0040_2005);
    chk("basic entryLo0", bus.entryLo0,      32'h0000_1007);
    chk("basic entryLo1", bus.entryLo1,      32'h0000_2007);
    chk("basic index",    32'(bus.index),    32'(m_rand));
    chk("basic random",   32'(bus.random),   32'(m_rand));
    last_idx = m_rand;
    tick();
    chk("basic busy c4",  32'(bus.busy),     32'd0);
    chk("basic wr c4",    32'(bus.writeTlb), 32'd0);
    chk("basic done c4",  32'(bus.done),     32'd0);
    chk("basic hold hi",  bus.entryHi,       32'h0040_2005);

    // Odd-page fault, with a stray missReq pulse during RD1
    start_walk(32'h0040_3ABC, 8'h05, 1'b0);
    serve("fault rd0", 32'h8000_2010, 32'h0000_1007, 0);
    bus.missReq = 1'b1;
    serve("fault rd1", 32'h8000_2014, 32'h0000_2005, 0);
    bus.missReq = 1'b0;
    chk("fault fault",    32'(bus.fault),    32'd1);
    chk("fault writeTlb", 32'(bus.writeTlb), 32'd0);
    chk("fault done",     32'(bus.done),     32'd0);
    chk("fault hold idx", 32'(bus.index),    32'(last_idx));
    chk("fault hold lo1", bus.entryLo1,      32'h0000_2007);
    tick();
    chk("fault busy c4",  32'(bus.busy),     32'd0);
    chk("fault pulse c4", 32'(bus.fault),    32'd0);
    tick();
    chk("stray busy",     32'(bus.busy),     32'd0);
    chk("stray memReq",   32'(bus.memReq),   32'd0);

    // Three wait states on each read: write lands in cycle 9
    start_walk(32'h0040_2ABC, 8'h3C, 1'b0);
    serve("ws rd0", 32'h8000_2010, 32'h0000_3017, 3);
    serve("ws rd1", 32'h8000_2014, 32'h0000_4017, 3);
    chk("ws writeTlb", 32'(bus.writeTlb), 32'd1);
    chk("ws done",     32'(bus.done),     32'd1);
    chk("ws entryHi",  bus.entryHi,       32'h0040_203C);
    chk("ws entryLo0", bus.entryLo0,      32'h0000_3017);
    chk("ws entryLo1", bus.entryLo1,      32'h0000_4017);
    chk("ws index",    32'(bus.index),    32'(m_rand));
    tick();
    chk("ws busy c10", 32'(bus.busy),     32'd0);

    // Back-to-back: missReq held, second request presented while busy
    start_walk(32'h0040_2ABC, 8'h05, 1'b1);
    bus.missVAddr = 32'h0080_6000;
    bus.asid      = 8'h11;
    serve("b2b a rd0", 32'h8000_2010, 32'h0000_1007, 0);
    serve("b2b a rd1", 32'h8000_2014, 32'h0000_2007, 0);
    chk("b2b a writeTlb", 32'(bus.writeTlb), 32'd1);
    chk("b2b a entryHi",  bus.entryHi,       32'h0040_2005);
    chk("b2b a index",    32'(bus.index),    32'(m_rand));
    tick();
    chk("b2b idle busy",   32'(bus.busy),   32'd0);
    chk("b2b idle memReq", 32'(bus.memReq), 32'd0);
    tick();
    bus.missReq = 1'b0;
    chk("b2b b busy", 32'(bus.busy), 32'd1);
    serve("b2b b rd0", 32'h8000_4030, 32'h0000_5007, 0);
    serve("b2b b rd1", 32'h8000_4034, 32'h0000_6007, 0);
    chk("b2b b writeTlb", 32'(bus.writeTlb), 32'd1);
    chk("b2b b entryHi",  bus.entryHi,       32'h0080_6011);
    chk("b2b b entryLo0", bus.entryLo0,      32'h0000_5007);
    chk("b2b b entryLo1", bus.entryLo1,      32'h0000_6007);
    chk("b2b b index",    32'(bus.index),    32'(m_rand));
    tick();
    chk("b2b b busy end", 32'(bus.busy),     32'd0);

    // Reset in RD1 while the ack is present
    start_walk(32'h0040_2ABC, 8'h05, 1'b0);
    serve("mid rd0", 32'h8000_2010, 32'h0000_1007, 0);
    chk("mid rd1 memReq",  32'(bus.memReq), 32'd1);
    chk("mid rd1 memAddr", bus.memAddr,     32'h8000_2014);
    bus.memAck  = 1'b1;
    bus.memData = 32'h0000_2007;
    res = 1'b1;
    tick();
    res = 1'b0;
    bus.memAck = 1'b0;
    chk("mid memReq",   32'(bus.memReq),   32'd0);
    chk("mid busy",     32'(bus.busy),     32'd0);
    chk("mid writeTlb", 32'(bus.writeTlb), 32'd0);
    chk("mid done",     32'(bus.done),     32'd0);
    chk("mid fault",    32'(bus.fault),    32'd0);
    chk("mid random",   32'(bus.random),   32'd63);
    chk("mid entryHi",  bus.entryHi,       32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post writeTlb", 32'(bus.writeTlb), 32'd0);
      chk("post done",     32'(bus.done),     32'd0);
      chk("post fault",    32'(bus.fault),    32'd0);
      chk("post busy",     32'(bus.busy),     32'd0);
    end
    chk("post random", 32'(bus.random), 32'(m_rand));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
